// File: rtl/ahb_gpio_pkg.sv
// Shared register offsets, AHB transfer encodings and the parity helper for the GPIO peripheral.
package ahb_gpio_pkg;

  localparam int unsigned ADDR_IDX_W = 3;

  localparam logic [ADDR_IDX_W-1:0] OFF_DATA     = 3'd0;
  localparam logic [ADDR_IDX_W-1:0] OFF_DIR      = 3'd1;
  localparam logic [ADDR_IDX_W-1:0] OFF_IRQ_EN   = 3'd2;
  localparam logic [ADDR_IDX_W-1:0] OFF_IRQ_POL  = 3'd3;
  localparam logic [ADDR_IDX_W-1:0] OFF_IRQ_STAT = 3'd4;
  localparam logic [ADDR_IDX_W-1:0] OFF_PERR     = 3'd5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // XOR-reduce with the odd/even select folded in: as a generator it yields the
  // parity bit for a data word; applied to a full bus it yields 1 on a parity failure.
  function automatic logic xor_parity(input logic [32:0] v, input logic odd);
    return (^v) ^ odd;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Input synchroniser chain plus one history flop and per-bit rise/fall detection.
module gpio_in_sync #(
  parameter int unsigned N      = 17,
  parameter int unsigned STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_pins,
  output logic [N-1:0] o_sync,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall
);

  logic [STAGES-1:0][N-1:0] r_stage;
  logic [N-1:0]             r_prev;

  // Shift pins through the synchroniser; r_prev holds the previous synchronised value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '0;
      r_prev  <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_pins};
      r_prev  <= r_stage[STAGES-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO with direction control, edge interrupts (W1C) and pin-bus parity.
module ahb_gpio_irq
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  output logic             HREADYOUT,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH:0]   GPIOIN,
  output logic [WIDTH:0]   GPIOOUT,
  output logic [WIDTH-1:0] GPIODIR,
  input  logic             PARITYSEL,
  output logic             PARITYERR,
  output logic             IRQ
);

  localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
  localparam int unsigned PRIME_W   = $clog2(PRIME_MAX + 1);

  logic                  r_wr;
  logic                  r_rd;
  logic [ADDR_IDX_W-1:0] r_addr;
  logic [WIDTH-1:0]      r_out;
  logic [WIDTH-1:0]      r_dir;
  logic [WIDTH-1:0]      r_en;
  logic [WIDTH-1:0]      r_pol;
  logic [WIDTH-1:0]      r_stat;
  logic                  r_perr;
  logic                  r_parity_err;
  logic [PRIME_W-1:0]    r_prime;

  logic [WIDTH:0]        w_sync;
  logic [WIDTH:0]        w_rise;
  logic [WIDTH:0]        w_fall;
  logic                  w_accept;
  logic                  w_primed;
  logic [WIDTH-1:0]      w_wdata;
  logic [WIDTH-1:0]      w_set;
  logic                  w_par_fail;
  logic                  w_perr_set;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  gpio_in_sync #(
    .N      (WIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_pins  (GPIOIN),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_accept   = HSEL & HREADY &
                      ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign w_primed   = (r_prime == PRIME_W'(PRIME_MAX));
  assign w_wdata    = HWDATA[WIDTH-1:0];
  assign w_set      = w_primed ?
                      (((r_pol & w_rise[WIDTH-1:0]) | (~r_pol & w_fall[WIDTH-1:0])) & ~r_dir) :
                      '0;
  assign w_par_fail = xor_parity(33'(w_sync), PARITYSEL);
  assign w_perr_set = w_primed & w_par_fail;

  // Register the address phase; the bus never stalls so HREADY alone qualifies it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= '0;
    end else if (HREADY) begin
      r_wr   <= w_accept & HWRITE;
      r_rd   <= w_accept & ~HWRITE;
      r_addr <= HADDR[4:2];
    end
  end

  // Hold off status and parity-error capture until the synchroniser holds real pin data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_prime <= '0;
    end else if (!w_primed) begin
      r_prime <= r_prime + PRIME_W'(1);
    end
  end

  // Register file: plain RW registers, W1C status where a new event beats the clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out        <= '0;
      r_dir        <= '0;
      r_en         <= '0;
      r_pol        <= '0;
      r_stat       <= '0;
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_wr && r_addr == OFF_DATA)    r_out <= w_wdata;
      if (r_wr && r_addr == OFF_DIR)     r_dir <= w_wdata;
      if (r_wr && r_addr == OFF_IRQ_EN)  r_en  <= w_wdata;
      if (r_wr && r_addr == OFF_IRQ_POL) r_pol <= w_wdata;
      r_stat       <= (r_stat & ~((r_wr && r_addr == OFF_IRQ_STAT) ? w_wdata : '0)) | w_set;
      r_perr       <= (r_perr & ~(r_wr && r_addr == OFF_PERR && HWDATA[0])) | w_perr_set;
      r_parity_err <= w_perr_set;
    end
  end

  // Read mux from the registered data-phase address.
  always_comb begin
    w_rdata = '0;
    case (r_addr)
      OFF_DATA:     w_rdata = 32'((r_dir & r_out) | (~r_dir & w_sync[WIDTH-1:0]));
      OFF_DIR:      w_rdata = 32'(r_dir);
      OFF_IRQ_EN:   w_rdata = 32'(r_en);
      OFF_IRQ_POL:  w_rdata = 32'(r_pol);
      OFF_IRQ_STAT: w_rdata = 32'(r_stat);
      OFF_PERR:     w_rdata = 32'(r_perr);
      default:      w_rdata = '0;
    endcase
  end

  assign HRDATA    = r_rd ? w_rdata : '0;
  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = {xor_parity(33'(r_out), PARITYSEL), r_out};
  assign GPIODIR   = r_dir;
  assign PARITYERR = r_parity_err;
  assign IRQ       = |(r_stat & r_en);

  // Address bits outside the decode window and the parity bit's edges are not used.
  assign w_unused = ^{HADDR[31:5], HADDR[1:0], HWDATA, w_rise[WIDTH], w_fall[WIDTH]};

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed bench for ahb_gpio_irq with a queue of expected values.
module tb_ahb_gpio_irq;

  localparam int unsigned W = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic [W:0]    GPIOIN;
  logic [W:0]    GPIOOUT;
  logic [W-1:0]  GPIODIR;
  logic          PARITYSEL;
  logic          PARITYERR;
  logic          IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ahb_gpio_irq #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .GPIOIN    (GPIOIN),
    .GPIOOUT   (GPIOOUT),
    .GPIODIR   (GPIODIR),
    .PARITYSEL (PARITYSEL),
    .PARITYERR (PARITYERR),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic push_exp(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(exp);
    check(tag, obs);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick();
    HWDATA = '0;
  endtask

  task automatic ahb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    push_exp(exp);
    check(tag, HRDATA);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HREADY = 1'b1; HWDATA = '0; GPIOIN = 17'h1FFFF; PARITYSEL = 1'b1;
    #1;
    // Reset values
    expect_now("rst_gpioout",   32'(GPIOOUT),   32'h0001_0000);
    expect_now("rst_gpiodir",   32'(GPIODIR),   32'h0);
    expect_now("rst_hrdata",    HRDATA,         32'h0);
    expect_now("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    expect_now("rst_irq",       32'(IRQ),       32'h0);
    expect_now("rst_parityerr", 32'(PARITYERR), 32'h0);
    repeat (3) tick();
    HRESETn = 1'b1;
    repeat (6) tick();
    // Pins high through reset: no status, no parity error during priming
    ahb_read("prime_stat", 32'h10, 32'h0);
    ahb_read("prime_perr", 32'h14, 32'h0);
    ahb_read("prime_data", 32'h00, 32'h0000_FFFF);
    expect_now("prime_parityerr", 32'(PARITYERR), 32'h0);

    // Mixed direction read-back and output parity
    PARITYSEL = 1'b0;
    GPIOIN = 17'h0_3C00;
    ahb_write(32'h04, 32'h0000_00FF);
    ahb_write(32'h00, 32'h0000_A5A5);
    ahb_read("data_mixed", 32'h00, 32'h0000_3CA5);
    expect_now("gpioout_even", 32'(GPIOOUT), 32'h0000_A5A5);
    expect_now("gpiodir",      32'(GPIODIR), 32'h0000_00FF);
    PARITYSEL = 1'b1;
    #1;
    expect_now("gpioout_odd",  32'(GPIOOUT), 32'h0001_A5A5);
    PARITYSEL = 1'b0;

    // Clear leftovers from the pin-bus change, set up interrupt on pin 8
    ahb_write(32'h10, 32'h0000_FFFF);
    ahb_write(32'h14, 32'h1);
    ahb_read("stat_cleared", 32'h10, 32'h0);
    ahb_read("perr_cleared", 32'h14, 32'h0);
    ahb_write(32'h08, 32'h0000_0100);
    ahb_write(32'h0C, 32'hFFFF_0100);
    ahb_read("pol_upper_ignored", 32'h0C, 32'h0000_0100);
    ahb_read("irq_en_rb",         32'h08, 32'h0000_0100);
    expect_now("irq_idle", 32'(IRQ), 32'h0);

    // Rising edge on pin 8 (pin 16 keeps the bus even)
    GPIOIN = 17'h1_3D00;
    tick();
    tick();
    expect_now("irq_early", 32'(IRQ), 32'h0);
    tick();
    expect_now("irq_rise",  32'(IRQ), 32'h1);
    expect_now("perr_none", 32'(PARITYERR), 32'h0);
    ahb_read("stat_pin8", 32'h10, 32'h0000_0100);
    ahb_write(32'h10, 32'h0000_0100);
    expect_now("irq_w1c", 32'(IRQ), 32'h0);

    // Pin 9 rise with falling polarity sets nothing
    GPIOIN = 17'h0_3F00;
    repeat (4) tick();
    ahb_read("stat_rise_ignored", 32'h10, 32'h0);

    // Pin 9 fall coinciding with a W1C of bit 9: the new event wins
    GPIOIN = 17'h1_3D00;
    tick();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0000_0200;
    tick();
    HWDATA = '0;
    ahb_read("stat_set_wins", 32'h10, 32'h0000_0200);
    ahb_write(32'h10, 32'h0000_0200);
    ahb_read("stat_w1c_9", 32'h10, 32'h0);

    // Input parity failure, sticky PERR
    ahb_read("perr_clean", 32'h14, 32'h0);
    GPIOIN = 17'h0_0001;
    tick();
    tick();
    expect_now("parityerr_early", 32'(PARITYERR), 32'h0);
    tick();
    expect_now("parityerr_set",   32'(PARITYERR), 32'h1);
    ahb_read("perr_set", 32'h14, 32'h1);
    GPIOIN = 17'h1_0001;
    repeat (3) tick();
    expect_now("parityerr_clr", 32'(PARITYERR), 32'h0);
    ahb_read("perr_sticky", 32'h14, 32'h1);
    ahb_write(32'h14, 32'h0);
    ahb_read("perr_w0", 32'h14, 32'h1);
    ahb_write(32'h14, 32'h1);
    ahb_read("perr_w1c", 32'h14, 32'h0);

    // Back-to-back write then read of DATA, unmapped offset
    ahb_write(32'h04, 32'h0000_FFFF);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
    tick();
    HWRITE = 1'b0; HADDR = 32'h00; HWDATA = 32'h0000_1234;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = '0;
    push_exp(32'h0000_1234);
    check("b2b_read", HRDATA);
    tick();
    expect_now("hrdata_idle",    HRDATA,         32'h0);
    expect_now("gpioout_1234",   32'(GPIOOUT),   32'h0001_1234);
    ahb_read("unmapped_1c", 32'h1C, 32'h0);

    // Reset mid-operation restarts everything including priming
    PARITYSEL = 1'b1;
    GPIOIN = 17'h1FFFF;
    HRESETn = 1'b0;
    #1;
    expect_now("mrst_gpioout", 32'(GPIOOUT), 32'h0001_0000);
    expect_now("mrst_gpiodir", 32'(GPIODIR), 32'h0);
    tick();
    tick();
    HRESETn = 1'b1;
    repeat (6) tick();
    ahb_read("mrst_perr", 32'h14, 32'h0);
    ahb_read("mrst_stat", 32'h10, 32'h0);
    ahb_read("mrst_dir",  32'h04, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_irq.md
# ahb_gpio_irq

Parametrised AHB-Lite GPIO peripheral: the next generation of the team's AHB GPIO, with configurable pin count, per-pin direction control, input synchronisation, edge-triggered interrupts with write-1-to-clear status, and selectable odd/even parity on both pin buses. It sits on the AHB-Lite slave fabric beside the other peripherals and drives one interrupt line to the system interrupt controller.

## Interface
- WIDTH, 16: data pins, 1..32
- SYNC_STAGES, 2: input synchroniser depth, ≥2
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address; only HADDR[4:2] decoded
- HTRANS  in  2  transfer type; NONSEQ/SEQ accepted
- HWRITE  in  1  1 = write
- HREADY  in  1  bus ready
- HREADYOUT  out  1  always 1, zero wait states
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- GPIOIN  in  WIDTH+1  pin inputs; MSB = parity bit
- GPIOOUT  out  WIDTH+1  pin outputs; MSB = generated parity
- GPIODIR  out  WIDTH  per-pin output enable, 1 = output
- PARITYSEL  in  1  1 = odd parity, 0 = even
- PARITYERR  out  1  registered input parity failure flag
- IRQ  out  1  interrupt, active high

## Operation
- Register map (offset, reset value): 0x00 DATA (0), 0x04 DIR (0), 0x08 IRQ_EN (0), 0x0C IRQ_POL (0; 1 = rising, 0 = falling), 0x10 IRQ_STAT (0, W1C), 0x14 PERR (0; bit0 sticky, W1C). Bits above WIDTH read 0 and ignore writes. Unmapped offsets read 0 and ignore writes.
- DATA write sets the output register. DATA read returns (DIR & out_reg) | (~DIR & in_sync[WIDTH-1:0]).
- GPIOOUT[WIDTH-1:0] = out_reg. GPIOOUT[WIDTH] is combinational parity of out_reg per PARITYSEL, so it equals PARITYSEL when out_reg = 0.
- Inputs pass through SYNC_STAGES flops, giving in_sync, then one more flop, giving in_prev. For a pin with DIR = 0, an edge matching IRQ_POL sets its IRQ_STAT bit. Output pins never set status.
- in_prev tracks every pin regardless of DIR, so changing DIR causes no spurious edge.
- IRQ = |(IRQ_STAT & IRQ_EN), OR of flops with no extra register.
- Parity check runs on the full in_sync bus (WIDTH+1 bits) per PARITYSEL every cycle. Result is registered into PARITYERR; failure also sets PERR bit0.
- Priming: a counter blocks status and parity-error setting for the first SYNC_STAGES+1 cycles after reset deassertion. Pins high at reset produce no edge.
- Simultaneous W1C and new event on the same bit: set wins. Writing 0 to a W1C bit has no effect.

## Timing
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. HADDR and HWRITE are registered.
- Writes take effect at the end of the data phase (register updated on the following edge).
- Read data is driven combinationally in the data phase from the registered address. HRDATA = 0 outside a read data phase.
- Back-to-back write then read of the same address returns the new value.
- Reset values: HREADYOUT 1, HRDATA 0, GPIOOUT {PARITYSEL, 0}, GPIODIR 0, IRQ 0, PARITYERR 0. Priming counter restarts on any reset, including mid-operation.
- Input-change latency: a pin change sampled at edge k sets IRQ_STAT and IRQ (if enabled) at edge k+SYNC_STAGES. PARITYERR follows at the same edge.

## Structure
- ahb_gpio_pkg: register offsets, HTRANS encodings, parity function.
- Sub-module gpio_in_sync: synchroniser, in_prev, and edge detect, instantiated once for the WIDTH+1 bus.
- Top level: AHB decode, register file, IRQ/parity logic, priming counter.

## Test plan
- Reset with GPIOIN = 0x1FFFF, PARITYSEL = 1 → no IRQ_STAT bits, PERR = 0, GPIOOUT = 0x10000.
- Write DIR = 0x00FF, DATA = 0xA5A5; read DATA with GPIOIN = 0x0_3C00 → 0x3CA5. With PARITYSEL = 0, GPIOOUT[16] = 0.
- IRQ_EN = 0x0100, IRQ_POL = 0x0100, rising edge on GPIOIN[8] → IRQ high 2 edges later. Write 0x0100 to IRQ_STAT → IRQ low the next cycle.
- Falling edge on pin 9 in the same cycle as a W1C of bit 9, with POL[9] = 0 → bit 9 remains set.
- GPIOIN = 0x0_0001, PARITYSEL = 0 → PARITYERR high after 2 edges, PERR reads 1. Fix parity (GPIOIN = 0x1_0001) → PARITYERR low, PERR remains 1 until a W1C write.
- Back-to-back write 0x1234 to DATA then read of DATA (DIR = 0xFFFF) → 0x1234. Read of offset 0x1C → 0.
